// File: rtl/uart_serial_receiver.sv
// 8N1 UART receiver with sticky ready/error flags, cleared by a one-cycle rx_clear pulse.
// Optional even-parity (8E1) support is compiled in when UART_RX_PARITY_EN is defined.
module uart_serial_receiver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Handshake: rx_ready rises when a good byte commits and stays high until a
  // cycle with rx_clear=1 while rx_ready=1; a commit in that same cycle wins.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  logic             sync_1;
  logic             rx_s;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             clear_ok;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`endif

  assign clear_ok = rx_clear && rx_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1      <= 1'b1;
      rx_s        <= 1'b1;
      state       <= S_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      rx_busy     <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      sync_1 <= rx_serial;
      rx_s   <= sync_1;

      // Clear first; a commit later in this block overrides it.
      if (clear_ok) begin
        rx_ready    <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err  <= 1'b0;
`endif
      end

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) begin
            state   <= S_START;
            rx_busy <= 1'b1;
          end
        end

        S_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            if (rx_s) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            par_bad <= (rx_s != ^shift_reg);
            state   <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (rx_s) begin
              // Return to IDLE immediately so a back-to-back start bit is caught.
              state    <= S_IDLE;
              rx_busy  <= 1'b0;
              rx_data  <= shift_reg;
              rx_ready <= 1'b1;
              if (rx_ready && !rx_clear) overrun_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              if (par_bad) parity_err <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          bit_cnt <= '0;
          if (rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_serial_receiver.sv
// Self-checking bench for uart_serial_receiver (CLKS_PER_BIT = 10), with a flag-level
// reference model and a byte scoreboard; covers both parity builds.
module tb_uart_serial_receiver;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS_AFTER_START = 10;
`else
  localparam int FRAME_BITS_AFTER_START = 9;
`endif
  localparam int LAT = 2 + CPB / 2 + FRAME_BITS_AFTER_START * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe_rises = 0;
  int ready_rises = 0;
  logic fe_prev = 1'b0;
  logic rdy_prev = 1'b0;

  logic [7:0] exp_q[$];

  // Reference model of the programmer-visible state.
  logic [7:0] m_data;
  logic       m_ready, m_over, m_frame, m_par;

  uart_serial_receiver #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .rx_clear(rx_clear),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
  );

  // Clock / cycle counter / edge monitors
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (frame_err === 1'b1 && fe_prev !== 1'b1) fe_rises++;
    if (rx_ready === 1'b1 && rdy_prev !== 1'b1) ready_rises++;
    fe_prev  = frame_err;
    rdy_prev = rx_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Model operations
  task automatic m_reset();
    m_data = 8'h00; m_ready = 1'b0; m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0;
  endtask

  task automatic m_clear();
    if (m_ready) begin
      m_ready = 1'b0; m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0;
    end
  endtask

  task automatic m_good(input logic [7:0] d, input logic par_ok, input logic clr);
    logic over_new;
    over_new = m_ready && !clr;
    if (clr) m_clear();
    m_data  = d;
    m_ready = 1'b1;
    if (over_new) m_over = 1'b1;
    if (!par_ok) m_par = 1'b1;
  endtask

  // Drivers (called at a negedge, return at a negedge)
  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_bit);
    rx_serial = 1'b1;
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
    m_clear();
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    m_reset();
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", rx_ready); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun_err, parity_err}); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int t0, lat;
    logic got;
    got = 1'b0; lat = -1;
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        for (int k = 0; k < 400 && !got; k++) begin
          @(negedge clk);
          if (rx_ready === 1'b1) begin got = 1'b1; lat = cyc - t0; end
        end
      end
    join
    m_good(8'hA5, 1'b1, 1'b0);
    checks++; if (!got) begin errors++; $display("FAIL single_timeout: rx_ready never rose within 400 cycles"); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    checks++; if (rx_data !== m_data) begin errors++; $display("FAIL single_data: got %h want %h", rx_data, m_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", rx_busy); end
    checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      errors++; $display("FAIL single_flags: got %b want 000", {frame_err, overrun_err, parity_err}); end
    pulse_clear();
    @(negedge clk);
    checks++; if (rx_ready !== m_ready) begin errors++; $display("FAIL single_clear: got %b want %b", rx_ready, m_ready); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, 1'b0);
    m_good(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    m_good(8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (rx_data !== m_data) begin errors++; $display("FAIL b2b_data: got %h want %h", rx_data, m_data); end
    checks++; if (overrun_err !== m_over) begin errors++; $display("FAIL b2b_overrun: got %b want %b", overrun_err, m_over); end
    checks++; if (rx_ready !== m_ready) begin errors++; $display("FAIL b2b_ready: got %b want %b", rx_ready, m_ready); end
    pulse_clear();
    @(negedge clk);
    checks++; if ({rx_ready, overrun_err} !== {m_ready, m_over}) begin
      errors++; $display("FAIL b2b_clear: got %b want %b", {rx_ready, overrun_err}, {m_ready, m_over}); end
  endtask

  task automatic test_glitch();
    int len;
    for (int n = 0; n < 3; n++) begin
      len = $urandom_range(1, 4);
      rx_serial = 1'b0;
      repeat (len) @(negedge clk);
      rx_serial = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++; if ({rx_ready, frame_err, rx_busy} !== {m_ready, m_frame, 1'b0}) begin
        errors++; $display("FAIL glitch_len%0d: got rdy/fe/busy %b want %b", len,
                           {rx_ready, frame_err, rx_busy}, {m_ready, m_frame, 1'b0}); end
    end
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = fe_rises;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    rx_serial = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    rx_serial = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    m_frame = 1'b1;
    checks++; if (frame_err !== m_frame) begin errors++; $display("FAIL frame_err: got %b want %b", frame_err, m_frame); end
    checks++; if (fe_rises - fe0 != 1) begin errors++; $display("FAIL frame_once: got %0d rises want 1", fe_rises - fe0); end
    checks++; if (rx_ready !== m_ready) begin errors++; $display("FAIL frame_ready: got %b want %b", rx_ready, m_ready); end
    checks++; if (rx_data !== m_data) begin errors++; $display("FAIL frame_data: got %h want %h", rx_data, m_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_clear_on_commit();
    send_frame(8'h11, 1'b1, 1'b0);
    m_good(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    fork
      send_frame(8'h81, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_clear = 1'b1;
        @(negedge clk);
        rx_clear = 1'b0;
      end
    join
    m_good(8'h81, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (rx_ready !== m_ready) begin errors++; $display("FAIL clrc_ready: got %b want %b", rx_ready, m_ready); end
    checks++; if (overrun_err !== m_over) begin errors++; $display("FAIL clrc_overrun: got %b want %b", overrun_err, m_over); end
    checks++; if (rx_data !== m_data) begin errors++; $display("FAIL clrc_data: got %h want %h", rx_data, m_data); end
    checks++; if (frame_err !== m_frame) begin errors++; $display("FAIL clrc_old_frame: got %b want %b", frame_err, m_frame); end
    pulse_clear();
  endtask

  task automatic test_reset_mid_frame();
    int r0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rx_serial = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", rx_busy); end
    rst = 1'b0;
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    m_reset();
    checks++; if ({rx_busy, rx_ready, rx_data} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL mid_reset: got busy/rdy/data %b %b %h want 0 0 00", rx_busy, rx_ready, rx_data); end
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    r0 = ready_rises;
    send_frame(8'h0F, 1'b1, 1'b0);
    m_good(8'h0F, 1'b1, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    checks++; if (rx_data !== m_data) begin errors++; $display("FAIL mid_data: got %h want %h", rx_data, m_data); end
    checks++; if (ready_rises - r0 != 1) begin errors++; $display("FAIL mid_count: got %0d bytes want 1", ready_rises - r0); end
    checks++; if ({frame_err, overrun_err, parity_err} !== {m_frame, m_over, m_par}) begin
      errors++; $display("FAIL mid_flags: got %b want %b", {frame_err, overrun_err, parity_err}, {m_frame, m_over, m_par}); end
    pulse_clear();
  endtask

  task automatic test_parity();
    logic par_ok;
`ifdef UART_RX_PARITY_EN
    par_ok = 1'b0;
`else
    par_ok = 1'b1;
`endif
    send_frame(8'h07, 1'b1, 1'b1);
    m_good(8'h07, par_ok, 1'b0);
    @(negedge clk);
    checks++; if (parity_err !== m_par) begin errors++; $display("FAIL parity_err: got %b want %b", parity_err, m_par); end
    checks++; if (rx_data !== m_data) begin errors++; $display("FAIL parity_data: got %h want %h", rx_data, m_data); end
    pulse_clear();
    @(negedge clk);
    checks++; if (parity_err !== m_par) begin errors++; $display("FAIL parity_clear: got %b want %b", parity_err, m_par); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] e;
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) pulse_clear();
      repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b0);
      m_good(d, 1'b1, 1'b0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (rx_data !== e) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", n, rx_data, e); end
      checks++; if ({rx_ready, overrun_err, frame_err} !== {m_ready, m_over, m_frame}) begin
        errors++; $display("FAIL rand_flags[%0d]: got %b want %b", n,
                           {rx_ready, overrun_err, frame_err}, {m_ready, m_over, m_frame}); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_clear_on_commit();
    test_reset_mid_frame();
    test_parity();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
